// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants for the FRANK6000 register bank.
//   OP_NOP / OP_LOAD / OP_INC / OP_DEC : write-port operation encoding
//   DEFAULT_WIDTH / DEFAULT_DEPTH      : default bank geometry
package regbank_pkg;

   localparam int unsigned OP_W          = 2;
   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 2'b00;
   localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
   localparam logic [OP_W-1:0] OP_INC  = 2'b10;
   localparam logic [OP_W-1:0] OP_DEC  = 2'b11;

endpackage : regbank_pkg

// File: rtl/regbank_next.sv
// regbank_next: combinational next-value / carry computation for one register.
// Shared by the write path and the optional bypass path so both always agree.
// Ports:
//   op       in  2      write-port operation
//   old_val  in  WIDTH  current register contents
//   wdata    in  WIDTH  load value
//   val_c    out WIDTH  value to be written
//   co_c     out 1      carry (INC) / borrow (DEC)
//   wr_en_c  out 1      register is written (op != NOP)
//   co_en_c  out 1      co flag is updated (INC or DEC)
module regbank_next
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] old_val,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] val_c,
   output logic             co_c,
   output logic             wr_en_c,
   output logic             co_en_c
);

   logic [WIDTH:0] inc_ext;
   logic [WIDTH:0] dec_ext;

   // Extend by one bit; bit WIDTH of the result is the carry or borrow.
   assign inc_ext = {1'b0, old_val} + (WIDTH+1)'(1);
   assign dec_ext = {1'b0, old_val} - (WIDTH+1)'(1);

   // Operation decode.
   always_comb begin
      val_c   = old_val;
      co_c    = 1'b0;
      wr_en_c = 1'b0;
      co_en_c = 1'b0;
      case (op)
         OP_LOAD: begin
            val_c   = wdata;
            wr_en_c = 1'b1;
         end
         OP_INC: begin
            val_c   = inc_ext[WIDTH-1:0];
            co_c    = inc_ext[WIDTH];
            wr_en_c = 1'b1;
            co_en_c = 1'b1;
         end
         OP_DEC: begin
            val_c   = dec_ext[WIDTH-1:0];
            co_c    = dec_ext[WIDTH];
            wr_en_c = 1'b1;
            co_en_c = 1'b1;
         end
         default: ;
      endcase
   end

endmodule : regbank_next

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH general-purpose register bank with one
// load/increment/decrement write port, a registered carry/borrow flag and
// two combinational read ports.
// Optional feature: define REGBANK_BYPASS_EN to forward the pending write
// value to a read port addressing waddr (suppressed while rst is high).
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   op       in  2      00 NOP, 01 LOAD, 10 INC, 11 DEC
//   waddr    in  AW     target register of op
//   wdata    in  WIDTH  load value
//   raddr_a  in  AW     read port A address
//   raddr_b  in  AW     read port B address
//   rdata_a  out WIDTH  contents of register raddr_a
//   rdata_b  out WIDTH  contents of register raddr_b
//   co       out 1      carry/borrow of the last INC/DEC
module register_bank
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  op,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             co
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] next_val;
   logic             next_co;
   logic             wr_en;
   logic             co_en;

   // Next value of the addressed register.
   regbank_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .op      (op),
      .old_val (regs[waddr]),
      .wdata   (wdata),
      .val_c   (next_val),
      .co_c    (next_co),
      .wr_en_c (wr_en),
      .co_en_c (co_en)
   );

   // Storage and carry flag; reset overrides any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
         co <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[waddr] <= next_val;
         end
         if (co_en) begin
            co <= next_co;
         end
      end
   end

`ifdef REGBANK_BYPASS_EN
   logic hit_a;
   logic hit_b;

   // Forward the pending write to a port reading the target register.
   assign hit_a = !rst && wr_en && (raddr_a == waddr);
   assign hit_b = !rst && wr_en && (raddr_b == waddr);

   assign rdata_a = hit_a ? next_val : regs[raddr_a];
   assign rdata_b = hit_b ? next_val : regs[raddr_b];
`else
   // Plain indexed reads of stored contents.
   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
`endif

endmodule : register_bank

// File: tb/tb_register_bank.sv
// tb_register_bank: directed self-checking bench for register_bank
// (WIDTH=8, DEPTH=4). Inputs change 1ns after a rising edge; outputs are
// sampled after settling, before the next edge.
module tb_register_bank;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] LOAD = 2'b01;
   localparam logic [1:0] INC  = 2'b10;
   localparam logic [1:0] DEC  = 2'b11;

   logic             clk;
   logic             rst;
   logic [1:0]       op;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    raddr_a;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             co;

   int checks;
   int errors;

   register_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b),
      .co      (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one operation for one edge, then return to NOP.
   task automatic step(input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d);
      op    = o;
      waddr = a;
      wdata = d;
      @(posedge clk);
      #1;
      op    = NOP;
      wdata = '0;
   endtask

   task automatic test_reset();
      // Power-up reset state.
      for (int i = 0; i < 4; i++) begin
         raddr_a = AW'(i);
         #1;
         checks++;
         if (rdata_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_init r%0d got %h want 00", i, rdata_a);
         end
      end
      checks++;
      if (co !== 1'b0) begin
         errors++;
         $display("FAIL reset_init_co got %b want 0", co);
      end
      // Set co=1, fill with 0x5A, then reset while LOAD is requested.
      step(LOAD, 2'd0, 8'hFF);
      step(INC, 2'd0, 8'h00);
      for (int i = 0; i < 4; i++) step(LOAD, AW'(i), 8'h5A);
      checks++;
      if (co !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_co got %b want 1", co);
      end
      rst = 1'b1;
      op = LOAD; waddr = 2'd2; wdata = 8'hA5;
      @(posedge clk);
      #1;
      rst = 1'b0; op = NOP;
      for (int i = 0; i < 4; i++) begin
         raddr_a = AW'(i);
         raddr_b = AW'(3 - i);
         #1;
         checks++;
         if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear r%0d got a=%h b=%h want 00", i, rdata_a, rdata_b);
         end
      end
      checks++;
      if (co !== 1'b0) begin
         errors++;
         $display("FAIL reset_co got %b want 0", co);
      end
   endtask

   task automatic test_load_dual();
      step(LOAD, 2'd1, 8'h12);
      step(LOAD, 2'd2, 8'h34);
      raddr_a = 2'd1; raddr_b = 2'd2;
      #1;
      checks++;
      if (rdata_a !== 8'h12 || rdata_b !== 8'h34) begin
         errors++;
         $display("FAIL load_dual got a=%h b=%h want 12/34", rdata_a, rdata_b);
      end
      raddr_a = 2'd2; raddr_b = 2'd2;
      #1;
      checks++;
      if (rdata_a !== 8'h34 || rdata_b !== 8'h34) begin
         errors++;
         $display("FAIL load_same got a=%h b=%h want 34/34", rdata_a, rdata_b);
      end
   endtask

   task automatic test_inc_wrap();
      raddr_a = 2'd3;
      step(LOAD, 2'd3, 8'hFE);
      step(INC, 2'd3, 8'h00);
      checks++;
      if (rdata_a !== 8'hFF || co !== 1'b0) begin
         errors++;
         $display("FAIL inc_ff got %h co=%b want ff co=0", rdata_a, co);
      end
      step(INC, 2'd3, 8'h00);
      checks++;
      if (rdata_a !== 8'h00 || co !== 1'b1) begin
         errors++;
         $display("FAIL inc_wrap got %h co=%b want 00 co=1", rdata_a, co);
      end
      step(LOAD, 2'd0, 8'h77);
      checks++;
      if (co !== 1'b1) begin
         errors++;
         $display("FAIL load_co_hold got %b want 1", co);
      end
   endtask

   task automatic test_dec_wrap();
      raddr_a = 2'd0;
      step(LOAD, 2'd0, 8'h01);
      step(DEC, 2'd0, 8'h00);
      checks++;
      if (rdata_a !== 8'h00 || co !== 1'b0) begin
         errors++;
         $display("FAIL dec_00 got %h co=%b want 00 co=0", rdata_a, co);
      end
      step(DEC, 2'd0, 8'h00);
      checks++;
      if (rdata_a !== 8'hFF || co !== 1'b1) begin
         errors++;
         $display("FAIL dec_wrap got %h co=%b want ff co=1", rdata_a, co);
      end
      // Count loop on r2 from 0.
      raddr_b = 2'd2;
      step(LOAD, 2'd2, 8'h00);
      for (int i = 1; i <= 10; i++) begin
         step(INC, 2'd2, 8'h00);
         checks++;
         if (rdata_b !== 8'(i) || co !== 1'b0) begin
            errors++;
            $display("FAIL count step %0d got %h co=%b want %h co=0", i, rdata_b, co, 8'(i));
         end
      end
   endtask

   task automatic test_isolation();
      logic [WIDTH-1:0] exp [4];
      for (int i = 0; i < 4; i++) begin
         step(LOAD, AW'(i), 8'h10 + 8'(i));
         exp[i] = 8'h10 + 8'(i);
      end
      for (int k = 0; k < 10; k++) step(INC, 2'd1, 8'hEE);
      exp[1] = 8'h1B;
      for (int i = 0; i < 4; i++) begin
         raddr_a = AW'(i);
         #1;
         checks++;
         if (rdata_a !== exp[i]) begin
            errors++;
            $display("FAIL isolation r%0d got %h want %h", i, rdata_a, exp[i]);
         end
      end
      for (int k = 0; k < 3; k++) step(NOP, AW'(k), 8'hC3);
      for (int i = 0; i < 4; i++) begin
         raddr_b = AW'(i);
         #1;
         checks++;
         if (rdata_b !== exp[i]) begin
            errors++;
            $display("FAIL nop_hold r%0d got %h want %h", i, rdata_b, exp[i]);
         end
      end
   endtask

   task automatic test_bypass();
      logic [WIDTH-1:0] pre_exp;
`ifdef REGBANK_BYPASS_EN
      pre_exp = 8'h08;
`else
      pre_exp = 8'h07;
`endif
      step(LOAD, 2'd1, 8'h07);
      op = INC; waddr = 2'd1; raddr_a = 2'd1;
      #1;
      checks++;
      if (rdata_a !== pre_exp) begin
         errors++;
         $display("FAIL bypass_pre got %h want %h", rdata_a, pre_exp);
      end
      @(posedge clk);
      #1;
      op = NOP;
      #1;
      checks++;
      if (rdata_a !== 8'h08) begin
         errors++;
         $display("FAIL bypass_post got %h want 08", rdata_a);
      end
      // Under reset the stored value is returned, then everything clears.
      rst = 1'b1; op = LOAD; waddr = 2'd1; wdata = 8'h55;
      #1;
      checks++;
      if (rdata_a !== 8'h08) begin
         errors++;
         $display("FAIL bypass_rst got %h want 08", rdata_a);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; op = NOP;
      #1;
      checks++;
      if (rdata_a !== 8'h00) begin
         errors++;
         $display("FAIL bypass_rst_clear got %h want 00", rdata_a);
      end
   endtask

   task automatic test_back_to_back_reset();
      raddr_a = 2'd0;
      op = INC; waddr = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      op = NOP;
      #1;
      checks++;
      if (rdata_a !== 8'h03) begin
         errors++;
         $display("FAIL b2b_inc got %h want 03", rdata_a);
      end
      op = INC;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      op = NOP;
      #1;
      checks++;
      if (rdata_a !== 8'h02 || co !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got %h co=%b want 02 co=0", rdata_a, co);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      op      = NOP;
      waddr   = '0;
      wdata   = '0;
      raddr_a = '0;
      raddr_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_load_dual();
      test_inc_wrap();
      test_dec_wrap();
      test_isolation();
      test_bypass();
      test_back_to_back_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_register_bank
